fir_filter: RTL and testbench

Parameterised direct-form FIR filter with N+1 taps, signed input samples and signed constant coefficients.
- One new sample is accepted every clock. The output is the full-precision convolution of the current sample with the previous N samples.
- Used as a leaf DSP block in sample-rate datapaths. There is no handshake: every clock edge is a valid sample.

---
 rtl/fir_filter.sv | 34 +++
 tb/tb_fir_filter.sv | 84 ++++++++
 2 files changed

// File: rtl/fir_filter.sv
// fir_filter: direct-form FIR with N+1 constant taps, full-precision signed output.
// Output is combinational from x; the delay line holds the previous N samples.
module fir_filter #(
  parameter int N = 3,
  parameter int W_X = 4,
  parameter int W_K = 4,
  parameter logic signed [W_K-1:0] K [N+1] = '{default: 1},
  parameter int W_Y = W_X + W_K + $clog2(N + 1)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic signed [W_X-1:0] x,
  output logic signed [W_Y-1:0] y
);
  localparam int W_P = W_X + W_K;
  logic signed [W_X-1:0] z_q [1:N];
  logic signed [W_X-1:0] z_d [1:N];
  logic signed [W_P-1:0] prod [N+1];
  assign prod[0] = W_P'(x) * W_P'(K[0]);
  for (genvar i = 1; i <= N; i++) begin : g_tap
    if (i == 1) begin : g_head
      assign z_d[i] = x;
    end else begin : g_body
      assign z_d[i] = z_q[i-1];
    end
    always_ff @(posedge clk) z_q[i] <= rstn ? '0 : z_d[i];
    assign prod[i] = W_P'(z_q[i]) * W_P'(K[i]);
  end
  // W_P-bit products cannot overflow; the sum gets clog2(N+1) guard bits.
  always_comb begin
    y = '0;
    for (int i = 0; i <= N; i++) y = y + W_Y'(prod[i]);
  end
endmodule

// File: tb/tb_fir_filter.sv
// tb_fir_filter: directed and random checks of fir_filter against three coefficient sets.
module tb_fir_filter;
  localparam logic signed [3:0] K1 [4] = '{1, 1, 1, 1};
  localparam logic signed [3:0] K2 [4] = '{1, -2, 3, -4};
  localparam logic signed [3:0] K3 [4] = '{-8, -8, -8, -8};
  logic clk = 1'b0;
  logic rstn = 1'b1;
  logic signed [3:0] x = '0;
  logic signed [9:0] y1, y2, y3;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  fir_filter #(.K(K1)) u_k1 (.clk(clk), .rstn(rstn), .x(x), .y(y1));
  fir_filter #(.K(K2)) u_k2 (.clk(clk), .rstn(rstn), .x(x), .y(y2));
  fir_filter #(.K(K3)) u_k3 (.clk(clk), .rstn(rstn), .x(x), .y(y3));
  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, act, exp);
    end
  endtask
  task automatic drive(input int xv, input bit r);
    @(negedge clk);
    x = 4'(xv);
    rstn = r;
    #2;
  endtask
  task automatic chk3(input string tag, input int e1, input int e2, input int e3);
    chk({tag, "_k1"}, int'(y1), e1);
    chk({tag, "_k2"}, int'(y2), e2);
    chk({tag, "_k3"}, int'(y3), e3);
  endtask
  task automatic seq5(input string tag, input int xs[5], input int e1[5], input int e2[5],
                      input int e3[5]);
    for (int i = 0; i < 5; i++) begin
      drive(xs[i], 1'b0);
      chk3($sformatf("%s_%0d", tag, i), e1[i], e2[i], e3[i]);
    end
  endtask
  initial begin
    int km1[4] = '{1, 1, 1, 1};
    int km2[4] = '{1, -2, 3, -4};
    int km3[4] = '{-8, -8, -8, -8};
    int hist[$];
    drive(0, 1'b1);
    drive(5, 1'b1);
    chk3("rst", 5, 5, -40);
    seq5("imp1", '{1, 0, 0, 0, 0}, '{1, 1, 1, 1, 0}, '{1, -2, 3, -4, 0},
         '{-8, -8, -8, -8, 0});
    drive(0, 1'b1);
    seq5("impn8", '{-8, 0, 0, 0, 0}, '{-8, -8, -8, -8, 0}, '{-8, 16, -24, 32, 0},
         '{64, 64, 64, 64, 0});
    drive(0, 1'b1);
    seq5("step7", '{7, 7, 7, 7, 7}, '{7, 14, 21, 28, 28}, '{7, -7, 14, -14, -14},
         '{-56, -112, -168, -224, -224});
    // history is still present until the reset edge itself
    drive(3, 1'b1);
    chk3("midrst", 24, -18, -192);
    seq5("after", '{3, 3, 3, 3, 3}, '{3, 6, 9, 12, 12}, '{3, -3, 6, -6, -6},
         '{-24, -48, -72, -96, -96});
    drive(0, 1'b1);
    seq5("neg8", '{-8, -8, -8, -8, -8}, '{-8, -16, -24, -32, -32}, '{-8, 8, -16, 16, 16},
         '{64, 128, 192, 256, 256});
    drive(0, 1'b1);
    hist = '{0, 0, 0};
    for (int c = 0; c < 200; c++) begin
      int xv, s1, s2, s3;
      xv = int'($urandom_range(0, 15)) - 8;
      drive(xv, 1'b0);
      hist.push_front(xv);
      s1 = 0; s2 = 0; s3 = 0;
      for (int i = 0; i < 4; i++) begin
        s1 += hist[i] * km1[i];
        s2 += hist[i] * km2[i];
        s3 += hist[i] * km3[i];
      end
      chk3($sformatf("rnd_%0d", c), s1, s2, s3);
      void'(hist.pop_back());
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
